cd_csr_host: RTL and testbench

//  CSR-bus initiator for one cdbus instance; converts frame streams to and from CSR accesses, with no CPU in the loop.

---
 rtl/cd_csr_host.sv | 180 ++++++++++++++++++
 tb/tb_cd_csr_host.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_csr_host.sv
// cd_csr_host: CSR-bus initiator for one cdbus instance, with no CPU in the loop.
// It polls INT_FLAG, drains received frames from the RX page to the rx byte stream,
// and loads frames from the tx byte stream into the TX page.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   irq                               cdbus interrupt (level)
//   csr_address/read/readdata         CSR read path (readdata is valid one cycle after the strobe)
//   csr_write/writedata               CSR write path
//   tx_data/valid/last, tx_ready      outgoing frame stream (src,dst,len,payload)
//   rx_data/valid/last, rx_ready      received frame stream (src,dst,len,payload)
//   tx_ovf, rx_lost, tx_err           single-cycle event pulses
module cd_csr_host #(
  parameter logic [4:0]  A_INT_FLAG  = 5'h10,
  parameter logic [4:0]  A_RX        = 5'h14,
  parameter logic [4:0]  A_TX        = 5'h15,
  parameter logic [4:0]  A_RX_CTRL   = 5'h16,
  parameter logic [4:0]  A_TX_CTRL   = 5'h17,
  parameter logic [15:0] POLL_PERIOD = 16'd1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       irq,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_last,
  input  logic       rx_ready,
  output logic       tx_ovf,
  output logic       rx_lost,
  output logic       tx_err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FLAG_RD,
    S_FLAG_WAIT,
    S_RX_RD,
    S_RX_WAIT,
    S_RX_HOLD,
    S_RX_REL,
    S_TX_DATA,
    S_TX_SEND
  } state_t;

  state_t      state, state_n;
  logic [15:0] poll_cnt;
  logic        poll_clr;
  logic        poll_due;
  logic [1:0]  rx_idx;   // 0..2 = header byte index, 3 = payload phase
  logic [7:0]  rx_rem;   // payload bytes still to deliver
  logic [7:0]  rx_hold;  // byte held while downstream stalls
  logic [8:0]  tx_cnt;   // bytes written to the TX page, saturates at 256
  logic [7:0]  rx_byte;
  logic        rx_is_last;

  assign poll_due = (poll_cnt == POLL_PERIOD - 16'd1);

  // The read byte is forwarded straight from csr_readdata in its valid cycle so a
  // byte can go out every two cycles; if the consumer stalls it comes from rx_hold.
  assign rx_byte    = (state == S_RX_WAIT) ? csr_readdata : rx_hold;
  assign rx_is_last = ((rx_idx == 2'd2) && (rx_byte == 8'h00)) ||
                      ((rx_idx == 2'd3) && (rx_rem == 8'd1));

  always_comb begin
    state_n       = state;
    poll_clr      = 1'b0;
    csr_address   = '0;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = '0;
    tx_ready      = 1'b0;
    rx_data       = '0;
    rx_valid      = 1'b0;
    rx_last       = 1'b0;
    tx_ovf        = 1'b0;
    rx_lost       = 1'b0;
    tx_err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (irq || poll_due) begin
          state_n  = S_FLAG_RD;
          poll_clr = 1'b1;
        end
      end
      S_FLAG_RD: begin
        csr_read    = 1'b1;
        csr_address = A_INT_FLAG;
        state_n     = S_FLAG_WAIT;
      end
      S_FLAG_WAIT: begin
        rx_lost = csr_readdata[3];
        tx_err  = csr_readdata[7];
        if (csr_readdata[1])                  state_n = S_RX_RD;
        else if (tx_valid && csr_readdata[5]) state_n = S_TX_DATA;
        else                                  state_n = S_IDLE;
      end
      S_RX_RD: begin
        csr_read    = 1'b1;
        csr_address = A_RX;
        state_n     = S_RX_WAIT;
      end
      S_RX_WAIT, S_RX_HOLD: begin
        rx_valid = 1'b1;
        rx_data  = rx_byte;
        rx_last  = rx_is_last;
        if (rx_ready) state_n = rx_is_last ? S_RX_REL : S_RX_RD;
        else          state_n = S_RX_HOLD;
      end
      S_RX_REL: begin
        csr_write     = 1'b1;
        csr_address   = A_RX_CTRL;
        csr_writedata = 8'h02;
        state_n       = S_FLAG_RD;
        poll_clr      = 1'b1;
      end
      S_TX_DATA: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          // Bytes beyond the 256-byte page are accepted but not written.
          if (!tx_cnt[8]) begin
            csr_write     = 1'b1;
            csr_address   = A_TX;
            csr_writedata = tx_data;
          end
          if (tx_last) begin
            tx_ovf  = tx_cnt[8];
            state_n = S_TX_SEND;
          end
        end
      end
      S_TX_SEND: begin
        csr_write     = 1'b1;
        csr_address   = A_TX_CTRL;
        csr_writedata = 8'h02;
        state_n       = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      poll_cnt <= '0;
      rx_idx   <= '0;
      rx_rem   <= '0;
      rx_hold  <= '0;
      tx_cnt   <= '0;
    end else begin
      state <= state_n;
      // Timer runs in every state and saturates, so a poll that fell due during
      // a long transfer is issued as soon as the FSM returns to IDLE.
      if (poll_clr)      poll_cnt <= '0;
      else if (!poll_due) poll_cnt <= poll_cnt + 16'd1;
      if (state == S_FLAG_WAIT) begin
        rx_idx <= '0;
        tx_cnt <= '0;
      end
      if (state == S_RX_WAIT) rx_hold <= csr_readdata;
      if (rx_valid && rx_ready) begin
        if (rx_idx != 2'd3) begin
          rx_idx <= rx_idx + 2'd1;
          if (rx_idx == 2'd2) rx_rem <= rx_byte;
        end else begin
          rx_rem <= rx_rem - 8'd1;
        end
      end
      if (state == S_TX_DATA && tx_valid && !tx_cnt[8]) tx_cnt <= tx_cnt + 9'd1;
    end
  end

endmodule

// File: tb/tb_cd_csr_host.sv
module tb_cd_csr_host;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       irq = 1'b0;
  logic [4:0] csr_address;
  logic       csr_read;
  logic [7:0] csr_readdata = 8'h00;
  logic       csr_write;
  logic [7:0] csr_writedata;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;
  logic       rx_ready = 1'b0;
  logic       tx_ovf, rx_lost, tx_err;

  cd_csr_host #(.POLL_PERIOD(16'd1000)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq),
    .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
    .tx_ovf(tx_ovf), .rx_lost(rx_lost), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // CSR slave model state
  logic [7:0]  flag_q[$];
  logic [7:0]  rx_page[$];
  logic [7:0]  tx_frame[$];
  // scoreboard
  logic [12:0] exp_wr[$];   // {address, data}
  logic [8:0]  exp_rx[$];   // {last, data}
  logic [12:0] e_wr;
  logic [8:0]  e_rx;
  // observations
  logic [4:0]  rd_addr[$];
  int          rd_cyc[$];
  int          rx_cyc[$];
  int          n_ovf, n_lost, n_err, n_viol;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (csr_read) begin
      if (csr_address == 5'h10)      csr_readdata <= (flag_q.size() != 0) ? flag_q.pop_front() : 8'h00;
      else if (csr_address == 5'h14) csr_readdata <= (rx_page.size() != 0) ? rx_page.pop_front() : 8'hEE;
      else                           csr_readdata <= 8'h00;
    end
  end

  always @(negedge clk) begin
    if (csr_read) begin
      rd_addr.push_back(csr_address);
      rd_cyc.push_back(cyc);
    end
    if (csr_read && (csr_write || tx_ready)) n_viol++;
    if (tx_ovf)  n_ovf++;
    if (rx_lost) n_lost++;
    if (tx_err)  n_err++;
    if (csr_write) begin
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL csr_write unexpected: got=%h required=none", {csr_address, csr_writedata});
      end else begin
        e_wr = exp_wr.pop_front();
        if ({csr_address, csr_writedata} !== e_wr) begin
          bad++;
          $display("FAIL csr_write: got=%h required=%h", {csr_address, csr_writedata}, e_wr);
        end
      end
    end
    if (rx_valid && rx_ready) begin
      rx_cyc.push_back(cyc);
      total++;
      if (exp_rx.size() == 0) begin
        bad++;
        $display("FAIL rx_byte unexpected: got=%h required=none", {rx_last, rx_data});
      end else begin
        e_rx = exp_rx.pop_front();
        if ({rx_last, rx_data} !== e_rx) begin
          bad++;
          $display("FAIL rx_byte: got=%h required=%h", {rx_last, rx_data}, e_rx);
        end
      end
    end
  end

  function automatic int count_reads(input logic [4:0] a);
    int n = 0;
    foreach (rd_addr[i]) if (rd_addr[i] == a) n++;
    return n;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; irq = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    flag_q.delete(); rx_page.delete(); exp_wr.delete(); exp_rx.delete();
    rd_addr.delete(); rd_cyc.delete(); rx_cyc.delete();
    n_ovf = 0; n_lost = 0; n_err = 0; n_viol = 0;
    reset_n = 1'b1;
  endtask

  task automatic pulse_irq();
    irq = 1'b1;
    @(posedge clk); #1;
    irq = 1'b0;
  endtask

  task automatic drive_tx(input int gap_at);
    int guard;
    for (int i = 0; i < tx_frame.size(); i++) begin
      if (i == gap_at) begin
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      tx_data = tx_frame[i]; tx_last = (i == tx_frame.size() - 1); tx_valid = 1'b1;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!tx_ready && guard < 5000);
      if (!tx_ready) begin
        total++; bad++;
        $display("FAIL tx_accept timeout: byte=%0d got=no_ready required=ready", i);
        break;
      end
      @(posedge clk); #1;
    end
    tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({csr_address, csr_read, csr_write, csr_writedata, tx_ready, rx_data, rx_valid,
         rx_last, tx_ovf, rx_lost, tx_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got=nonzero required=0");
    end
  endtask

  task automatic test_rx_basic();
    do_reset();
    flag_q = '{8'h02, 8'h00};
    rx_page = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    exp_rx = '{9'h001, 9'h002, 9'h003, 9'h0AA, 9'h0BB, 9'h1CC};
    exp_wr = '{{5'h16, 8'h02}};
    rx_ready = 1'b1;
    irq = 1'b1;
    @(posedge clk); #1;
    total++;
    if (!(csr_read === 1'b1 && csr_address === 5'h10)) begin
      bad++;
      $display("FAIL irq_latency: got read=%b addr=%h required read=1 addr=10", csr_read, csr_address);
    end
    irq = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (count_reads(5'h14) !== 6) begin bad++; $display("FAIL rx_basic_reads: got=%0d required=6", count_reads(5'h14)); end
    total++;
    if (count_reads(5'h10) !== 2) begin bad++; $display("FAIL rx_basic_flag_reads: got=%0d required=2", count_reads(5'h10)); end
    total++;
    if (rx_cyc.size() < 2 || rx_cyc[1] - rx_cyc[0] != 2) begin
      bad++; $display("FAIL rx_rate: got_entries=%0d required=2-cycle spacing", rx_cyc.size());
    end
    total++;
    if (exp_rx.size() + exp_wr.size() != 0) begin
      bad++; $display("FAIL rx_basic_missing: got=%0d left required=0", exp_rx.size() + exp_wr.size());
    end
  endtask

  task automatic test_rx_len0();
    do_reset();
    flag_q = '{8'h02, 8'h00};
    rx_page = '{8'h07, 8'h08, 8'h00, 8'h55};
    exp_rx = '{9'h007, 9'h008, 9'h100};
    exp_wr = '{{5'h16, 8'h02}};
    fork
      for (int k = 0; k < 60; k++) begin
        rx_ready = (k % 3 == 0);
        @(posedge clk); #1;
      end
      pulse_irq();
    join
    rx_ready = 1'b0;
    total++;
    if (count_reads(5'h14) !== 3) begin bad++; $display("FAIL len0_reads: got=%0d required=3", count_reads(5'h14)); end
    total++;
    if (exp_rx.size() + exp_wr.size() != 0) begin
      bad++; $display("FAIL len0_missing: got=%0d left required=0", exp_rx.size() + exp_wr.size());
    end
  endtask

  task automatic test_tx_basic();
    do_reset();
    flag_q = '{8'h20};
    tx_frame = '{8'h05, 8'h06, 8'h02, 8'h11, 8'h22};
    foreach (tx_frame[i]) exp_wr.push_back({5'h15, tx_frame[i]});
    exp_wr.push_back({5'h17, 8'h02});
    fork
      drive_tx(3);
      begin @(posedge clk); #1; pulse_irq(); end
    join
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (n_viol !== 0) begin bad++; $display("FAIL tx_ready_during_read: got=%0d required=0", n_viol); end
    total++;
    if (n_ovf !== 0) begin bad++; $display("FAIL tx_basic_ovf: got=%0d required=0", n_ovf); end
    total++;
    if (exp_wr.size() != 0) begin bad++; $display("FAIL tx_basic_missing: got=%0d left required=0", exp_wr.size()); end
  endtask

  task automatic test_tx_overflow();
    do_reset();
    flag_q = '{8'h20};
    tx_frame.delete();
    for (int i = 0; i < 300; i++) tx_frame.push_back(8'((i * 7 + 3) & 8'hFF));
    for (int i = 0; i < 256; i++) exp_wr.push_back({5'h15, tx_frame[i]});
    exp_wr.push_back({5'h17, 8'h02});
    fork
      drive_tx(-1);
      begin @(posedge clk); #1; pulse_irq(); end
    join
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (n_ovf !== 1) begin bad++; $display("FAIL tx_ovf_pulses: got=%0d required=1", n_ovf); end
    total++;
    if (exp_wr.size() != 0) begin bad++; $display("FAIL tx_ovf_missing: got=%0d left required=0", exp_wr.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    flag_q = '{8'h22, 8'h20};
    rx_page = '{8'h09, 8'h0A, 8'h01, 8'h5A};
    exp_rx = '{9'h009, 9'h00A, 9'h001, 9'h15A};
    tx_frame = '{8'h03, 8'h04, 8'h01, 8'h99};
    exp_wr.push_back({5'h16, 8'h02});
    foreach (tx_frame[i]) exp_wr.push_back({5'h15, tx_frame[i]});
    exp_wr.push_back({5'h17, 8'h02});
    rx_ready = 1'b1;
    fork
      drive_tx(-1);
      begin @(posedge clk); #1; pulse_irq(); end
    join
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (count_reads(5'h10) !== 2) begin bad++; $display("FAIL prio_flag_reads: got=%0d required=2", count_reads(5'h10)); end
    total++;
    if (exp_rx.size() + exp_wr.size() != 0) begin
      bad++; $display("FAIL prio_missing: got=%0d left required=0", exp_rx.size() + exp_wr.size());
    end
  endtask

  task automatic test_poll_and_flags();
    do_reset();
    repeat (2100) @(posedge clk);
    #1;
    total++;
    if (count_reads(5'h10) !== 2) begin bad++; $display("FAIL poll_count: got=%0d required=2", count_reads(5'h10)); end
    total++;
    if (rd_cyc.size() < 2 || rd_cyc[1] - rd_cyc[0] != 1000) begin
      bad++; $display("FAIL poll_period: got_entries=%0d required=1000-cycle spacing", rd_cyc.size());
    end
    do_reset();
    flag_q = '{8'h88};
    pulse_irq();
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (n_lost !== 1) begin bad++; $display("FAIL rx_lost_pulses: got=%0d required=1", n_lost); end
    total++;
    if (n_err !== 1) begin bad++; $display("FAIL tx_err_pulses: got=%0d required=1", n_err); end
  endtask

  task automatic test_reset_mid_rx();
    int guard;
    do_reset();
    flag_q = '{8'h02};
    rx_page = '{8'h01, 8'h02, 8'h05, 8'h10, 8'h20};
    pulse_irq();
    guard = 0;
    while (!rx_valid && guard < 50) begin @(negedge clk); guard++; end
    total++;
    if (rx_valid !== 1'b1) begin bad++; $display("FAIL mid_rx_start: got=%b required=1", rx_valid); end
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({csr_address, csr_read, csr_write, csr_writedata, tx_ready, rx_data, rx_valid,
         rx_last, tx_ovf, rx_lost, tx_err} !== '0) begin
      bad++;
      $display("FAIL mid_rx_reset_outputs: got=nonzero required=0");
    end
    reset_n = 1'b1;
    rd_addr.delete();
    rx_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (count_reads(5'h14) !== 0) begin bad++; $display("FAIL mid_rx_followup: got=%0d required=0", count_reads(5'h14)); end
    rx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_rx_len0();
    test_tx_basic();
    test_tx_overflow();
    test_back_to_back();
    test_poll_and_flags();
    test_reset_mid_rx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
